pipeline_run_ctrl: RTL and testbench
====================================

// Module: pipeline_run_ctrl
// PURPOSE
//  Execution controller between the UART debugger and the pipeline. Turns decoded debug commands
//  (RUN, STEP n, STOP, breakpoint set/clear) into the pipeline clock-enable (o_enable).
//  Stops the pipeline on program halt, PC breakpoint or user STOP, and reports the stop cause.
//  Counts enabled cycles. Sits beside the debugger interface, which issues commands and reads status.
// PARAMETERS
//  PC      32  width of program counter / breakpoint address
//  STEP_W  8   width of step-count argument
//  CNT_W   32  width of enabled-cycle counter
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_reset      in   1       synchronous reset, active-low
//  i_cmd_valid  in   1       command strobe from debugger
//  i_cmd        in   3       0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 SET_BP, 5 CLR_BP, 6-7 NOP
//  i_cmd_arg    in   PC      STEP: count in [STEP_W-1:0]; SET_BP: breakpoint address
//  o_cmd_ready  out  1       command is accepted when valid && ready
//  i_pc         in   PC      current pipeline PC
//  i_halt       in   1       HALT instruction retired by the pipeline
//  o_enable     out  1       pipeline enable (registered)
//  o_done       out  1       one-cycle pulse on leaving RUN/STEP
//  o_cause      out  3       0 NONE, 1 HALT, 2 BREAK, 3 STEP_DONE, 4 USER_STOP
//  o_state      out  2       0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//  o_bp_en      out  1       breakpoint armed
//  o_cycles     out  CNT_W   count of cycles with o_enable=1; saturates at all-ones
// BEHAVIOUR
//  Reset (i_reset=0 at an edge): state IDLE; o_enable, o_done, o_cause, o_bp_en, o_cycles, bp_addr
//   and step counter all 0. Applies mid-RUN/STEP: o_enable is 0 the next cycle.
//  o_cmd_ready = (state != HALTED). An accepted command takes effect at that edge.
//   o_enable changes from the next cycle (1-cycle latency).
//  IDLE:
//   RUN -> RUN.
//   STEP -> STEP; count N = arg[STEP_W-1:0], N=0 treated as 1.
//   SET_BP: bp_addr <= arg, o_bp_en <= 1. CLR_BP: o_bp_en <= 0. STOP/NOP: no effect.
//   Entering RUN/STEP sets o_cause <= NONE.
//  RUN: o_enable=1. Exit conditions are evaluated at each edge while o_enable=1, in priority order:
//   i_halt -> HALTED, cause HALT.
//   bp hit (o_bp_en && i_pc==bp_addr, not first enabled cycle) -> IDLE, cause BREAK.
//   STOP accepted -> IDLE, cause USER_STOP.
//  STEP: o_enable=1 for exactly N consecutive cycles; counter decrements each enabled cycle.
//   Exit conditions, in priority order: i_halt > bp hit > STOP > count reaches 0.
//   Count reaching 0 -> IDLE, cause STEP_DONE.
//  Breakpoint mask: the compare is ignored on the first enabled cycle after entering RUN/STEP,
//   so resuming from a breakpoint PC does not re-trigger.
//  SET_BP/CLR_BP in RUN/STEP: accepted and applied; the new value is used from the next cycle.
//   RUN/STEP commands in RUN/STEP: accepted, ignored.
//  HALTED: terminal until reset. o_enable=0, o_cmd_ready=0, o_cause held.
//  o_done: 1 for exactly one cycle, the first cycle with o_enable=0 after RUN/STEP.
//   Same cycle that o_cause and o_state show the new values.
//  o_cycles increments on every cycle with o_enable=1; holds at 2^CNT_W-1; cleared only by reset.
//  o_enable falls in the cycle after the exit edge. The pipeline therefore executes the
//   halting/breakpoint cycle and no further cycles.
// TESTING
//  Reset mid-RUN: hold i_reset=0 one edge -> next cycle o_enable=0, o_state=0, o_cycles=0, o_bp_en=0.
//  STEP arg=5 from IDLE -> o_enable high exactly 5 cycles, then o_done pulse, o_cause=3,
//   o_cycles=5. STEP arg=0 -> 1 cycle.
//  SET_BP 0x0000_0010, RUN, drive i_pc 0,4,8,0x10 -> o_enable falls after 0x10 edge, o_cause=2.
//   RUN again with i_pc=0x10 -> no immediate re-break.
//  RUN, i_halt=1 and STOP valid on same edge -> o_state=3, o_cause=1, o_cmd_ready=0;
//   later RUN commands are ignored.
//  RUN 3 cycles, STOP -> o_cause=4, o_cycles=3 (+1 for the STOP cycle); CLR_BP then RUN
//   past 0x10 -> no break.
//  Saturation with CNT_W=4: RUN 20 cycles -> o_cycles=15 and held.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// Run/step/stop controller between the UART debugger and the pipeline.
// Drives the pipeline clock-enable and reports why the pipeline stopped.
module pipeline_run_ctrl #(
  parameter int PC     = 32,
  parameter int STEP_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [2:0]        i_cmd,
  input  logic [PC-1:0]     i_cmd_arg,
  output logic              o_cmd_ready,
  input  logic [PC-1:0]     i_pc,
  input  logic              i_halt,
  output logic              o_enable,
  output logic              o_done,
  output logic [2:0]        o_cause,
  output logic [1:0]        o_state,
  output logic              o_bp_en,
  output logic [CNT_W-1:0]  o_cycles
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [2:0] C_RUN  = 3'd1;
  localparam logic [2:0] C_STEP = 3'd2;
  localparam logic [2:0] C_STOP = 3'd3;
  localparam logic [2:0] C_SET  = 3'd4;
  localparam logic [2:0] C_CLR  = 3'd5;

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_HALT = 3'd1;
  localparam logic [2:0] K_BRK  = 3'd2;
  localparam logic [2:0] K_STEP = 3'd3;
  localparam logic [2:0] K_USER = 3'd4;

  localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);
  localparam logic [CNT_W-1:0]  CYC_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic [2:0]        cause_q, cause_d;
  logic              bp_en_q, bp_en_d;
  logic [PC-1:0]     bp_addr_q, bp_addr_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;

  logic accept;
  logic bp_hit;

  assign accept = i_cmd_valid && (state_q != S_HALTED);
  assign bp_hit = bp_en_q && (i_pc == bp_addr_q) && !first_q;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cause_d   = cause_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    cyc_d     = cyc_q;

    if (en_q && !(&cyc_q))
      cyc_d = cyc_q + CYC_ONE;

    // Breakpoint edits apply in any non-terminal state
    if (accept && i_cmd == C_SET) begin
      bp_en_d   = 1'b1;
      bp_addr_d = i_cmd_arg;
    end
    if (accept && i_cmd == C_CLR)
      bp_en_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept && i_cmd == C_RUN) begin
          state_d = S_RUN;
          cause_d = K_NONE;
          first_d = 1'b1;
        end else if (accept && i_cmd == C_STEP) begin
          state_d = S_STEP;
          cause_d = K_NONE;
          first_d = 1'b1;
          cnt_d   = (i_cmd_arg[STEP_W-1:0] == '0)
                    ? CNT_ONE : i_cmd_arg[STEP_W-1:0];
        end
      end
      S_RUN, S_STEP: begin
        first_d = 1'b0;
        if (i_halt) begin
          state_d = S_HALTED;
          cause_d = K_HALT;
          done_d  = 1'b1;
        end else if (bp_hit) begin
          state_d = S_IDLE;
          cause_d = K_BRK;
          done_d  = 1'b1;
        end else if (accept && i_cmd == C_STOP) begin
          state_d = S_IDLE;
          cause_d = K_USER;
          done_d  = 1'b1;
        end else if (state_q == S_STEP) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            cause_d = K_STEP;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: ;
    endcase

    en_d = (state_d == S_RUN) || (state_d == S_STEP);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      cause_q   <= K_NONE;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      cyc_q     <= cyc_d;
    end
  end

  assign o_cmd_ready = (state_q != S_HALTED);
  assign o_enable    = en_q;
  assign o_done      = done_q;
  assign o_cause     = cause_q;
  assign o_state     = state_q;
  assign o_bp_en     = bp_en_q;
  assign o_cycles    = cyc_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [31:0] arg;
  logic [31:0] pc;
  logic        halt;

  logic        ready, en, done, bp_en;
  logic [2:0]  cause;
  logic [1:0]  state;
  logic [31:0] cycles;

  logic        ready4, en4, done4, bp_en4;
  logic [2:0]  cause4;
  logic [1:0]  state4;
  logic [3:0]  cycles4;

  int n_cmp = 0;
  int n_err = 0;

  int      m_state;
  int      m_cause;
  int      m_done;
  int      m_bp_en;
  longint  m_bp_addr;
  int      m_left;
  int      m_since;
  longint  m_cyc;

  always #5 clk = ~clk;

  pipeline_run_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_cmd_arg(arg), .o_cmd_ready(ready), .i_pc(pc), .i_halt(halt),
    .o_enable(en), .o_done(done), .o_cause(cause), .o_state(state),
    .o_bp_en(bp_en), .o_cycles(cycles)
  );

  pipeline_run_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_cmd_arg(arg), .o_cmd_ready(ready4), .i_pc(pc), .i_halt(halt),
    .o_enable(en4), .o_done(done4), .o_cause(cause4), .o_state(state4),
    .o_bp_en(bp_en4), .o_cycles(cycles4)
  );

  // Reference: one call per rising edge, from the inputs seen at that edge
  task automatic model_edge();
    bit run_on, acc;
    int c;
    run_on = (m_state == 1) || (m_state == 2);
    acc    = cmd_valid && (m_state != 3);
    c      = int'(cmd);
    m_done = 0;
    if (!rst_n) begin
      m_state = 0; m_cause = 0; m_bp_en = 0; m_bp_addr = 0;
      m_left = 0; m_since = 0; m_cyc = 0;
      return;
    end
    if (run_on) begin
      bit hit;
      m_cyc++;
      hit = m_bp_en && (longint'(pc) == m_bp_addr) && (m_since > 0);
      m_since++;
      if (halt) begin
        m_state = 3; m_cause = 1; m_done = 1;
      end else if (hit) begin
        m_state = 0; m_cause = 2; m_done = 1;
      end else if (acc && c == 3) begin
        m_state = 0; m_cause = 4; m_done = 1;
      end else if (m_state == 2) begin
        m_left--;
        if (m_left == 0) begin
          m_state = 0; m_cause = 3; m_done = 1;
        end
      end
    end else if (m_state == 0 && acc && (c == 1 || c == 2)) begin
      m_state = c;
      m_cause = 0;
      m_since = 0;
      m_left  = (arg[7:0] == 0) ? 1 : int'(arg[7:0]);
    end
    if (acc && c == 4) begin
      m_bp_en = 1; m_bp_addr = longint'(arg);
    end
    if (acc && c == 5) m_bp_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a);
    cmd_valid = 1'b1; cmd = c; arg = a;
    tick();
    cmd_valid = 1'b0; cmd = 3'd0; arg = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; arg = '0;
    pc = '0; halt = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    issue(3'd4, 32'h40);
    issue(3'd1, 32'h0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp += 5;
    if (en !== 1'b0) begin n_err++;
      $display("FAIL reset_enable got %b want 0", en); end
    if (state !== 2'd0) begin n_err++;
      $display("FAIL reset_state got %0d want 0", state); end
    if (cycles !== 32'd0) begin n_err++;
      $display("FAIL reset_cycles got %0d want 0", cycles); end
    if (bp_en !== 1'b0) begin n_err++;
      $display("FAIL reset_bp_en got %b want 0", bp_en); end
    if (ready !== 1'b1 || done !== 1'b0 || cause !== 3'd0) begin n_err++;
      $display("FAIL reset_misc got rdy=%b done=%b cause=%0d want 1 0 0",
               ready, done, cause); end
  endtask

  task automatic test_step(input int n);
    int on_cnt, done_cnt, want;
    want = (n == 0) ? 1 : n;
    do_reset();
    issue(3'd2, 32'(n));
    on_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (en) on_cnt++;
      if (done) done_cnt++;
      if (done && cause !== 3'd3) begin n_err++;
        $display("FAIL step_cause got %0d want 3", cause); end
      tick();
    end
    n_cmp += 4;
    if (on_cnt != want) begin n_err++;
      $display("FAIL step%0d_enables got %0d want %0d", n, on_cnt, want); end
    if (done_cnt != 1) begin n_err++;
      $display("FAIL step%0d_done got %0d want 1", n, done_cnt); end
    if (cycles !== 32'(want)) begin n_err++;
      $display("FAIL step%0d_cycles got %0d want %0d", n, cycles, want); end
    if (cause !== 3'd3 || state !== 2'd0) begin n_err++;
      $display("FAIL step%0d_end got cause=%0d st=%0d want 3 0",
               n, cause, state); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    issue(3'd4, 32'h10);
    issue(3'd1, 32'h0);
    pc = 32'h0; tick();
    pc = 32'h4; tick();
    pc = 32'h8; tick();
    pc = 32'h10;
    n_cmp++;
    if (en !== 1'b1) begin n_err++;
      $display("FAIL bp_before got en=%b want 1", en); end
    tick();
    n_cmp += 2;
    if (en !== 1'b0 || done !== 1'b1) begin n_err++;
      $display("FAIL bp_stop got en=%b done=%b want 0 1", en, done); end
    if (cause !== 3'd2 || state !== 2'd0) begin n_err++;
      $display("FAIL bp_cause got cause=%0d st=%0d want 2 0", cause, state); end
    issue(3'd1, 32'h0);
    tick();
    n_cmp++;
    if (en !== 1'b1 || cause !== 3'd0) begin n_err++;
      $display("FAIL bp_resume got en=%b cause=%0d want 1 0", en, cause); end
    pc = 32'h20;
    issue(3'd3, 32'h0);
  endtask

  task automatic test_halt();
    do_reset();
    issue(3'd1, 32'h0);
    tick();
    halt = 1'b1;
    issue(3'd3, 32'h0);
    halt = 1'b0;
    n_cmp += 2;
    if (state !== 2'd3 || cause !== 3'd1) begin n_err++;
      $display("FAIL halt_state got st=%0d cause=%0d want 3 1", state, cause); end
    if (ready !== 1'b0 || done !== 1'b1 || en !== 1'b0) begin n_err++;
      $display("FAIL halt_flags got rdy=%b done=%b en=%b want 0 1 0",
               ready, done, en); end
    for (int i = 0; i < 3; i++) begin
      issue(3'd1, 32'h0);
      tick();
      n_cmp++;
      if (en !== 1'b0 || state !== 2'd3 || cause !== 3'd1) begin n_err++;
        $display("FAIL halt_terminal got en=%b st=%0d cause=%0d want 0 3 1",
                 en, state, cause); end
    end
  endtask

  task automatic test_stop_clr();
    do_reset();
    issue(3'd1, 32'h0);
    tick(); tick(); tick();
    issue(3'd3, 32'h0);
    n_cmp += 2;
    if (cause !== 3'd4 || en !== 1'b0) begin n_err++;
      $display("FAIL stop_cause got cause=%0d en=%b want 4 0", cause, en); end
    if (cycles !== 32'd4) begin n_err++;
      $display("FAIL stop_cycles got %0d want 4", cycles); end
    issue(3'd4, 32'h10);
    issue(3'd5, 32'h0);
    n_cmp++;
    if (bp_en !== 1'b0) begin n_err++;
      $display("FAIL clr_bp got %b want 0", bp_en); end
    issue(3'd1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      pc = 32'(i * 4);
      tick();
      n_cmp++;
      if (en !== 1'b1) begin n_err++;
        $display("FAIL clr_nobreak pc=%h got en=%b want 1", pc, en); end
    end
    issue(3'd3, 32'h0);
  endtask

  task automatic test_saturation();
    do_reset();
    issue(3'd1, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    n_cmp += 2;
    if (cycles4 !== 4'hf) begin n_err++;
      $display("FAIL sat_cycles4 got %0d want 15", cycles4); end
    if (cycles !== 32'd20) begin n_err++;
      $display("FAIL sat_cycles32 got %0d want 20", cycles); end
    tick(); tick(); tick();
    n_cmp++;
    if (cycles4 !== 4'hf) begin n_err++;
      $display("FAIL sat_hold got %0d want 15", cycles4); end
    issue(3'd3, 32'h0);
  endtask

  task automatic test_random();
    int exp_en;
    longint exp4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd       = 3'($urandom_range(0, 7));
      arg       = (cmd == 3'd2) ? 32'($urandom_range(0, 9))
                                : 32'($urandom_range(0, 7) * 4);
      pc        = 32'($urandom_range(0, 7) * 4);
      halt      = ($urandom_range(0, 59) == 0);
      tick();
      exp_en = (m_state == 1 || m_state == 2) ? 1 : 0;
      exp4   = (m_cyc > 15) ? 15 : m_cyc;
      n_cmp += 4;
      if (en !== 1'(exp_en) || ready !== 1'(m_state != 3)) begin n_err++;
        $display("FAIL rnd_en[%0d] got en=%b rdy=%b want %0d %0d",
                 i, en, ready, exp_en, m_state != 3); end
      if (state !== 2'(m_state) || cause !== 3'(m_cause)) begin n_err++;
        $display("FAIL rnd_st[%0d] got st=%0d cause=%0d want %0d %0d",
                 i, state, cause, m_state, m_cause); end
      if (done !== 1'(m_done) || bp_en !== 1'(m_bp_en)) begin n_err++;
        $display("FAIL rnd_flags[%0d] got done=%b bp=%b want %0d %0d",
                 i, done, bp_en, m_done, m_bp_en); end
      if (cycles !== 32'(m_cyc) || cycles4 !== 4'(exp4)) begin n_err++;
        $display("FAIL rnd_cyc[%0d] got %0d/%0d want %0d/%0d",
                 i, cycles, cycles4, m_cyc, exp4); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = '0; arg = '0;
    pc = '0; halt = 1'b0;
    test_reset();
    test_step(5);
    test_step(0);
    test_breakpoint();
    test_halt();
    test_stop_clr();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
